// File: rtl/pwm_capt_pkg.sv
// Shared definitions for the PWM capture block: FSM state encoding,
// status bit positions and the input synchronizer depth.
package pwm_capt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } state_e;

  localparam int VLD        = 0;
  localparam int OVF        = 1;
  localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/pwm_capt_edge.sv
// Input conditioning for pwm_capt: 2-flop synchronizer, optional glitch
// filter (compiled in with PWMCAPT_FILTER_EN) and rise/fall detection.
module pwmcapt_edge
  import pwm_capt_pkg::*;
(
  input  logic clk,
  input  logic arstz,
  input  logic pwm_i,
  output logic rise,
  output logic fall
);

  logic [SYNC_DEPTH-1:0] sync_q;
  logic                  pwm_s;
  logic                  pwm_d;

  // Bring the asynchronous PWM input into the clk domain.
  always_ff @(posedge clk or negedge arstz) begin
    if (!arstz) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_DEPTH-2:0], pwm_i};
  end

`ifdef PWMCAPT_FILTER_EN
  logic tap_q;
  logic filt_q;

  // Majority-of-all filter: the level only moves once two consecutive
  // synchronized samples agree, so single-clk pulses never reach pwm_s.
  always_ff @(posedge clk or negedge arstz) begin
    if (!arstz) begin
      tap_q  <= 1'b0;
      filt_q <= 1'b0;
    end else begin
      tap_q <= sync_q[SYNC_DEPTH-1];
      if (sync_q[SYNC_DEPTH-1] && tap_q)        filt_q <= 1'b1;
      else if (!sync_q[SYNC_DEPTH-1] && !tap_q) filt_q <= 1'b0;
    end
  end

  assign pwm_s = filt_q;
`else
  assign pwm_s = sync_q[SYNC_DEPTH-1];
`endif

  // Delayed copy of the conditioned level for edge detection.
  always_ff @(posedge clk or negedge arstz) begin
    if (!arstz) pwm_d <= 1'b0;
    else        pwm_d <= pwm_s;
  end

  assign rise = pwm_s & ~pwm_d;
  assign fall = ~pwm_s & pwm_d;

endmodule

// File: rtl/pwm_capt.sv
// PWM capture: measures high time and rise-to-rise period in base-rate
// ticks, publishing results with W1C status bits and set-pulse IRQs.
// Optional glitch filter in the input path: define PWMCAPT_FILTER_EN.
module pwm_capt
  import pwm_capt_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             arstz,
  input  logic             tick,
  input  logic             en,
  input  logic             pwm_i,
  input  logic [1:0]       clr,
  output logic [CNT_W-1:0] hi_cnt,
  output logic [CNT_W-1:0] per_cnt,
  output logic [1:0]       sta,
  output logic [1:0]       irq
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] hi_lat_q;
  logic [CNT_W-1:0] tick_w;
  logic             rise;
  logic             fall;
  logic             sat;
  logic             done;
  logic             ovf_set;
  logic             lat_hi;
  logic [1:0]       set;

  pwmcapt_edge u_edge (
    .clk   (clk),
    .arstz (arstz),
    .pwm_i (pwm_i),
    .rise  (rise),
    .fall  (fall)
  );

  assign tick_w = {{(CNT_W-1){1'b0}}, tick};
  assign sat    = (cnt_q == CNT_MAX) && tick;

  // Measurement FSM and counter: saturation aborts the measurement ahead
  // of any edge, and dropping en discards whatever was being counted.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
    ovf_set = 1'b0;
    lat_hi  = 1'b0;
    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = ARM;
          cnt_d   = '0;
        end
        ARM: begin
          if (rise) begin
            state_d = HIGH;
            cnt_d   = tick_w;
          end
        end
        HIGH: begin
          if (sat) begin
            ovf_set = 1'b1;
            state_d = ARM;
            cnt_d   = '0;
          end else if (fall) begin
            lat_hi  = 1'b1;
            cnt_d   = cnt_q + tick_w;
            state_d = LOW;
          end else begin
            cnt_d = cnt_q + tick_w;
          end
        end
        LOW: begin
          if (sat) begin
            ovf_set = 1'b1;
            state_d = ARM;
            cnt_d   = '0;
          end else if (rise) begin
            done    = 1'b1;
            cnt_d   = tick_w;
            state_d = HIGH;
          end else begin
            cnt_d = cnt_q + tick_w;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // FSM state and running tick counter.
  always_ff @(posedge clk or negedge arstz) begin
    if (!arstz) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // High time is held privately until the period closes, so hi_cnt and
  // per_cnt always describe the same PWM cycle.
  always_ff @(posedge clk or negedge arstz) begin
    if (!arstz) begin
      hi_lat_q <= '0;
      hi_cnt   <= '0;
      per_cnt  <= '0;
    end else begin
      if (lat_hi) hi_lat_q <= cnt_q;
      if (done) begin
        hi_cnt  <= hi_lat_q;
        per_cnt <= cnt_q;
      end
    end
  end

  assign set[VLD] = done;
  assign set[OVF] = ovf_set;
  assign irq      = set & ~sta;

  // Sticky status with write-one-to-clear; a clear wins over a same-cycle set.
  always_ff @(posedge clk or negedge arstz) begin
    if (!arstz) sta <= '0;
    else        sta <= ~clr & (sta | set);
  end

endmodule

// File: tb/tb_pwm_capt.sv
// Self-checking bench for pwm_capt: random PWM waveforms and tick patterns
// compared against tick sums taken over the edge-delayed waveform windows.
module tb_pwm_capt;

  localparam int CNT_W = 8;
`ifdef PWMCAPT_FILTER_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif
  localparam int HIST = 8192;

  logic             clk   = 1'b0;
  logic             arstz = 1'b0;
  logic             tick  = 1'b0;
  logic             en    = 1'b0;
  logic             pwm_i = 1'b0;
  logic [1:0]       clr   = 2'b00;
  logic [CNT_W-1:0] hi_cnt;
  logic [CNT_W-1:0] per_cnt;
  logic [1:0]       sta;
  logic [1:0]       irq;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int tick_mode = 0;
  int irq0_seen = 0;
  int irq1_seen = 0;
  int last_irq1 = -1;
  bit tick_hist [HIST];

  always #5 clk = ~clk;

  pwm_capt #(.CNT_W(CNT_W)) dut (
    .clk     (clk),
    .arstz   (arstz),
    .tick    (tick),
    .en      (en),
    .pwm_i   (pwm_i),
    .clr     (clr),
    .hi_cnt  (hi_cnt),
    .per_cnt (per_cnt),
    .sta     (sta),
    .irq     (irq)
  );

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Number of ticks driven in cycles [a, b).
  function automatic int tsum(input int a, input int b);
    int s = 0;
    for (int i = a; i < b; i++)
      if (i >= 0 && i < HIST) s += int'(tick_hist[i]);
    return s;
  endfunction

  task automatic step(input logic p, input logic [1:0] c);
    @(posedge clk);
    #1;
    pwm_i = p;
    clr   = c;
    case (tick_mode)
      0:       tick = 1'b1;
      1:       tick = (cyc % 4 == 0);
      default: tick = 1'($urandom_range(0, 1));
    endcase
    if (cyc < HIST) tick_hist[cyc] = tick;
    cyc++;
    @(negedge clk);
    if (irq[0]) irq0_seen++;
    if (irq[1]) begin
      irq1_seen++;
      last_irq1 = cyc - 1;
    end
  endtask

  task automatic run(input int n, input logic p);
    repeat (n) step(p, 2'b00);
  endtask

  task automatic apply_reset();
    arstz = 1'b0;
    en    = 1'b0;
    pwm_i = 1'b0;
    clr   = 2'b00;
    tick  = 1'b0;
    repeat (3) @(posedge clk);
    #1 arstz = 1'b1;
  endtask

  task automatic test_reset();
    arstz = 1'b0;
    en    = 1'b1;
    pwm_i = 1'b1;
    tick  = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (hi_cnt !== '0)  begin bad++; $display("[TB] FAIL reset_hi got=%0d want=0", hi_cnt); end
    total++; if (per_cnt !== '0) begin bad++; $display("[TB] FAIL reset_per got=%0d want=0", per_cnt); end
    total++; if (sta !== 2'b00)  begin bad++; $display("[TB] FAIL reset_sta got=%b want=00", sta); end
    total++; if (irq !== 2'b00)  begin bad++; $display("[TB] FAIL reset_irq got=%b want=00", irq); end
  endtask

  task automatic test_measure();
    int  h, l, r, prev_r, prev_f, base0, exp_hi, exp_per, exp_irq;
    bit  doclr, sta0;
    apply_reset();
    tick_mode = 0;
    en = 1'b1;
    run(5, 1'b0);
    sta0 = 1'b0; exp_hi = 0; exp_per = 0; prev_r = 0; prev_f = 0;
    for (int k = 0; k < 9; k++) begin
      tick_mode = (k < 3) ? 0 : ((k < 6) ? 1 : 2);
      if (k < 2) begin h = 30; l = 70; end
      else begin h = $urandom_range(6, 40); l = $urandom_range(2, 40); end
      doclr = (k > 0) && ($urandom_range(0, 1) == 1);
      base0 = irq0_seen;
      r = cyc;
      for (int j = 0; j < h; j++) begin
        step(1'b1, (j == LAT && doclr) ? 2'b01 : 2'b00);
        if (j == LAT + 1) begin
          if (k > 0) begin
            exp_hi  = tsum(prev_r + LAT, prev_f + LAT);
            exp_per = tsum(prev_r + LAT, r + LAT);
            exp_irq = sta0 ? 0 : 1;
            sta0    = !doclr;
          end else begin
            exp_irq = 0;
          end
          total++; if (int'(hi_cnt) !== exp_hi)   begin bad++; $display("[TB] FAIL measure_hi k=%0d got=%0d want=%0d", k, hi_cnt, exp_hi); end
          total++; if (int'(per_cnt) !== exp_per) begin bad++; $display("[TB] FAIL measure_per k=%0d got=%0d want=%0d", k, per_cnt, exp_per); end
          total++; if (sta !== {1'b0, sta0})      begin bad++; $display("[TB] FAIL measure_sta k=%0d got=%b want=%b", k, sta, {1'b0, sta0}); end
          total++; if (irq0_seen - base0 !== exp_irq) begin bad++; $display("[TB] FAIL measure_irq0 k=%0d got=%0d want=%0d", k, irq0_seen - base0, exp_irq); end
        end
      end
      prev_r = r;
      prev_f = cyc;
      run(l, 1'b0);
    end
  endtask

  task automatic test_overflow();
    int r, base0, base1, exp_cyc;
    apply_reset();
    tick_mode = 0;
    en = 1'b1;
    run(4, 1'b0);
    base0 = irq0_seen;
    base1 = irq1_seen;
    r = cyc;
    run(300, 1'b1);
    exp_cyc = r + LAT + (1 << CNT_W) - 1;
    total++; if (irq1_seen - base1 !== 1)  begin bad++; $display("[TB] FAIL ovf_count got=%0d want=1", irq1_seen - base1); end
    total++; if (last_irq1 !== exp_cyc)    begin bad++; $display("[TB] FAIL ovf_time got=%0d want=%0d", last_irq1, exp_cyc); end
    total++; if (sta !== 2'b10)            begin bad++; $display("[TB] FAIL ovf_sta got=%b want=10", sta); end
    total++; if (irq0_seen - base0 !== 0)  begin bad++; $display("[TB] FAIL ovf_nodone got=%0d want=0", irq0_seen - base0); end
    total++; if (hi_cnt !== '0 || per_cnt !== '0) begin bad++; $display("[TB] FAIL ovf_results got=%0d/%0d want=0/0", hi_cnt, per_cnt); end
    run(300, 1'b1);
    total++; if (irq1_seen - base1 !== 1)  begin bad++; $display("[TB] FAIL ovf_once got=%0d want=1", irq1_seen - base1); end
  endtask

  task automatic test_en_drop();
    int ra, fa, rb, rd, fd, re, base0, old_hi, old_per, exp_hi, exp_per;
    tick_mode = 0;
    step(1'b1, 2'b10);
    step(1'b1, 2'b00);
    total++; if (sta !== 2'b00) begin bad++; $display("[TB] FAIL endrop_clr got=%b want=00", sta); end
    run(10, 1'b0);
    ra = cyc; run(20, 1'b1);
    fa = cyc; run(30, 1'b0);
    rb = cyc; run(12, 1'b1);
    old_hi  = tsum(ra + LAT, fa + LAT);
    old_per = tsum(ra + LAT, rb + LAT);
    total++; if (int'(hi_cnt) !== old_hi)   begin bad++; $display("[TB] FAIL endrop_hi0 got=%0d want=%0d", hi_cnt, old_hi); end
    total++; if (int'(per_cnt) !== old_per) begin bad++; $display("[TB] FAIL endrop_per0 got=%0d want=%0d", per_cnt, old_per); end
    step(1'b1, 2'b01);
    base0 = irq0_seen;
    en = 1'b0;
    run(5, 1'b1);
    en = 1'b1;
    run(6, 1'b1);
    run(15, 1'b0);
    rd = cyc; run(25, 1'b1);
    fd = cyc; run(35, 1'b0);
    total++; if (irq0_seen - base0 !== 0) begin bad++; $display("[TB] FAIL endrop_nodone got=%0d want=0", irq0_seen - base0); end
    total++; if (int'(hi_cnt) !== old_hi || int'(per_cnt) !== old_per) begin bad++; $display("[TB] FAIL endrop_hold got=%0d/%0d want=%0d/%0d", hi_cnt, per_cnt, old_hi, old_per); end
    re = cyc; run(LAT + 2, 1'b1);
    exp_hi  = tsum(rd + LAT, fd + LAT);
    exp_per = tsum(rd + LAT, re + LAT);
    total++; if (irq0_seen - base0 !== 1)    begin bad++; $display("[TB] FAIL endrop_done got=%0d want=1", irq0_seen - base0); end
    total++; if (int'(hi_cnt) !== exp_hi)   begin bad++; $display("[TB] FAIL endrop_hi got=%0d want=%0d", hi_cnt, exp_hi); end
    total++; if (int'(per_cnt) !== exp_per) begin bad++; $display("[TB] FAIL endrop_per got=%0d want=%0d", per_cnt, exp_per); end
  endtask

  task automatic test_glitch();
    int ra, rg, fb, rb, exp_hi, exp_per;
    apply_reset();
    tick_mode = 0;
    en = 1'b1;
    run(5, 1'b0);
    ra = cyc; run(10, 1'b1);
    run(1, 1'b0);
    rg = cyc; run(10, 1'b1);
    fb = cyc; run(20, 1'b0);
    rb = cyc; run(LAT + 2, 1'b1);
`ifdef PWMCAPT_FILTER_EN
    exp_hi  = tsum(ra + LAT, fb + LAT);
    exp_per = tsum(ra + LAT, rb + LAT);
`else
    exp_hi  = tsum(rg + LAT, fb + LAT);
    exp_per = tsum(rg + LAT, rb + LAT);
`endif
    total++; if (int'(hi_cnt) !== exp_hi)   begin bad++; $display("[TB] FAIL glitch_hi got=%0d want=%0d (first rise at %0d)", hi_cnt, exp_hi, ra); end
    total++; if (int'(per_cnt) !== exp_per) begin bad++; $display("[TB] FAIL glitch_per got=%0d want=%0d", per_cnt, exp_per); end
  endtask

  initial begin
    test_reset();
    test_measure();
    test_overflow();
    test_en_drop();
    test_glitch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
